// File: rtl/ex_alu_unit.sv
// ex_alu_unit: execute-stage ALU with valid/ready handshake on both sides and registered outputs.
// Shifts iterate one bit per cycle by default; define ALU_BARREL_SHIFT_EN for single-cycle shifts.
module ex_alu_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [XLEN-1:0]  op_a_i,
  input  logic [XLEN-1:0]  op_b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  result_o,
  output logic             zero_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_SRL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               zero_q, zero_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [XLEN-1:0]    acc_q, acc_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [3:0]         sop_q, sop_d;
  logic [TAG_W-1:0]   stag_q, stag_d;

  logic [SHW-1:0]     shamt;
  logic               is_shift;
  logic               defer_c;
  logic [XLEN-1:0]    alu_res;
  logic [XLEN-1:0]    acc_step;

  assign shamt    = op_b_i[SHW-1:0];
  assign is_shift = (alu_ctrl_i == OP_SLL) || (alu_ctrl_i == OP_SRL) || (alu_ctrl_i == OP_SRA);

`ifdef ALU_BARREL_SHIFT_EN
  assign defer_c = 1'b0;
  assign ready_o = (!valid_q || ready_i) && !flush_i;
  assign busy_o  = 1'b0;
`else
  assign defer_c = is_shift && (shamt != '0);
  assign ready_o = (state_q == IDLE) && (!valid_q || ready_i) && !flush_i;
  assign busy_o  = (state_q == SHIFT);
`endif

  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign tag_o    = tag_q;

  // Single-cycle datapath; opcodes 10-15 fall through to ADD.
  always_comb begin
    alu_res = op_a_i + op_b_i;
    case (alu_ctrl_i)
      OP_ADD:  alu_res = op_a_i + op_b_i;
      OP_AND:  alu_res = op_a_i & op_b_i;
      OP_OR:   alu_res = op_a_i | op_b_i;
      OP_XOR:  alu_res = op_a_i ^ op_b_i;
`ifdef ALU_BARREL_SHIFT_EN
      OP_SLL:  alu_res = op_a_i << shamt;
      OP_SRL:  alu_res = op_a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op_a_i) >>> shamt);
`else
      // Only reached with a zero shift amount; non-zero amounts go iterative.
      OP_SLL, OP_SRL, OP_SRA: alu_res = op_a_i;
`endif
      OP_SUB:  alu_res = op_a_i - op_b_i;
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (op_a_i < op_b_i)};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      default: alu_res = op_a_i + op_b_i;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    case (sop_q)
      OP_SLL:  acc_step = {acc_q[XLEN-2:0], 1'b0};
      OP_SRA:  acc_step = {acc_q[XLEN-1], acc_q[XLEN-1:1]};
      default: acc_step = {1'b0, acc_q[XLEN-1:1]};
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q && !ready_i;
    result_d = result_q;
    zero_d   = zero_q;
    tag_d    = tag_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sop_d    = sop_q;
    stag_d   = stag_q;

    if (flush_i) begin
      state_d = IDLE;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_o) begin
            if (defer_c) begin
              acc_d   = op_a_i;
              cnt_d   = shamt;
              sop_d   = alu_ctrl_i;
              stag_d  = tag_i;
              valid_d = 1'b0;
              state_d = SHIFT;
            end else begin
              result_d = alu_res;
              zero_d   = (alu_res == '0);
              tag_d    = tag_i;
              valid_d  = 1'b1;
            end
          end
        end
        SHIFT: begin
          acc_d = acc_step;
          cnt_d = cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_d = acc_step;
            zero_d   = (acc_step == '0);
            tag_d    = stag_q;
            valid_d  = 1'b1;
            state_d  = IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      tag_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sop_q    <= '0;
      stag_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      tag_q    <= tag_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sop_q    <= sop_d;
      stag_q   <= stag_d;
    end
  end

endmodule

// File: tb/tb_ex_alu_unit.sv
// tb_ex_alu_unit: directed plus randomized checks of ex_alu_unit against a queue-based reference model.
// Build with ALU_BARREL_SHIFT_EN to check the single-cycle shifter variant.
module tb_ex_alu_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [3:0]       alu_ctrl_i;
  logic [XLEN-1:0]  op_a_i;
  logic [XLEN-1:0]  op_b_i;
  logic [TAG_W-1:0] tag_i;
  logic             valid_o;
  logic             ready_i;
  logic [XLEN-1:0]  result_o;
  logic             zero_o;
  logic [TAG_W-1:0] tag_o;
  logic             busy_o;

  ex_alu_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (flush_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .alu_ctrl_i (alu_ctrl_i),
    .op_a_i     (op_a_i),
    .op_b_i     (op_b_i),
    .tag_i      (tag_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .result_o   (result_o),
    .zero_o     (zero_o),
    .tag_o      (tag_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;

  exp_t q[$];
  int   n      = 0;
  int   checks = 0;
  int   passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference results from the opcode table, independent of any hardware structure.
  function automatic logic [XLEN-1:0] ref_alu(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int k;
    logic [XLEN-1:0] r;
    k = int'(b[4:0]);
    case (op)
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = a ^ b;
      4'd4: r = a << k;
      4'd5: r = a >> k;
      4'd6: begin
        r = a >> k;
        if (a[XLEN-1] && k > 0) r = r | ~(32'hFFFF_FFFF >> k);
      end
      4'd7: r = a - b;
      4'd8: r = (a < b) ? 32'd1 : 32'd0;
      4'd9: r = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
      default: r = a + b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] op, input logic [XLEN-1:0] b);
`ifdef ALU_BARREL_SHIFT_EN
    return 0;
`else
    if ((op == 4'd4 || op == 4'd5 || op == 4'd6) && b[4:0] != 5'd0) return int'(b[4:0]);
    return 0;
`endif
  endfunction

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk_i) begin : mon
    logic exp_v;
    logic exp_busy;
    logic exp_ready;
    exp_t e;
    n++;
    if (!rst_ni) begin
      q.delete();
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
    end else begin
      exp_v     = (q.size() > 0) && (n >= q[0].due);
      exp_busy  = (q.size() > 0) && (n < q[0].due);
      exp_ready = !exp_busy && (!exp_v || ready_i) && !flush_i;
      chk("valid_o", 32'(valid_o), 32'(exp_v));
      chk("busy_o", 32'(busy_o), 32'(exp_busy));
      chk("ready_o", 32'(ready_o), 32'(exp_ready));
      if (exp_v && valid_o) begin
        chk("result_o", result_o, q[0].res);
        chk("zero_o", 32'(zero_o), 32'(q[0].res == 32'd0));
        chk("tag_o", 32'(tag_o), 32'(q[0].tag));
      end
      if (flush_i) begin
        q.delete();
      end else begin
        if (exp_v && ready_i) void'(q.pop_front());
        if (valid_i && exp_ready) begin
          e.res = ref_alu(alu_ctrl_i, op_a_i, op_b_i);
          e.tag = tag_i;
          e.due = n + 1 + ref_lat(alu_ctrl_i, op_b_i);
          q.push_back(e);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [TAG_W-1:0] t, output int waits);
    waits      = 0;
    valid_i    = 1'b1;
    alu_ctrl_i = op;
    op_a_i     = a;
    op_b_i     = b;
    tag_i      = t;
    @(negedge clk_i);
    while (!ready_o && waits < 200) begin
      @(negedge clk_i);
      waits++;
    end
    if (waits >= 200) chk("send_timeout", 32'(waits), 32'd0);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int w;
    int c;
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    alu_ctrl_i = '0; op_a_i = '0; op_b_i = '0; tag_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_result", result_o, 32'd0);
    chk("reset_zero", 32'(zero_o), 32'd0);
    chk("reset_tag", 32'(tag_o), 32'd0);
    chk("reset_valid", 32'(valid_o), 32'd0);
    rst_ni = 1'b1;

    send(4'd0, 32'd5, 32'd7, 5'd3, w);
    chk("add_result", result_o, 32'd12);
    chk("add_valid", 32'(valid_o), 32'd1);
    chk("add_zero", 32'(zero_o), 32'd0);
    chk("add_tag", 32'(tag_o), 32'd3);
    send(4'd15, 32'd5, 32'd7, 5'd4, w);
    chk("op15_result", result_o, 32'd12);

    send(4'd7, 32'h1234, 32'h1234, 5'd5, w);
    chk("sub_result", result_o, 32'd0);
    chk("sub_zero", 32'(zero_o), 32'd1);
    send(4'd9, 32'hFFFF_FFFF, 32'd1, 5'd6, w);
    chk("slt_result", result_o, 32'd1);
    send(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd7, w);
    chk("sltu_result", result_o, 32'd0);

    send(4'd6, 32'h8000_0000, 32'h24, 5'd9, w);
`ifndef ALU_BARREL_SHIFT_EN
    chk("sra_busy", 32'(busy_o), 32'd1);
    chk("sra_ready", 32'(ready_o), 32'd0);
`endif
    c = 0;
    while (!valid_o && c < 50) begin
      @(posedge clk_i); #1; c++;
    end
`ifdef ALU_BARREL_SHIFT_EN
    chk("sra_latency", 32'(c), 32'd0);
`else
    chk("sra_latency", 32'(c), 32'd4);
`endif
    chk("sra_result", result_o, 32'hF800_0000);
    chk("sra_tag", 32'(tag_o), 32'd9);

    send(4'd4, 32'hA5A5_0F0F, 32'h20, 5'd11, w);
    chk("sll0_result", result_o, 32'hA5A5_0F0F);
    chk("sll0_valid", 32'(valid_o), 32'd1);

    // Backpressure: result held while a new request waits.
    send(4'd0, 32'd100, 32'd23, 5'd7, w);
    ready_i = 1'b0;
    valid_i = 1'b1; alu_ctrl_i = 4'd0; op_a_i = 32'd0; op_b_i = 32'd1; tag_i = 5'd10;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      chk("hold_result", result_o, 32'd123);
      chk("hold_tag", 32'(tag_o), 32'd7);
      chk("hold_ready", 32'(ready_o), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      ready_i = 1'b1; valid_i = 1'b1; alu_ctrl_i = 4'd0;
      op_a_i = 32'(i * 10); op_b_i = 32'd1; tag_i = 5'(10 + i);
      @(posedge clk_i); #1;
      chk("b2b_valid", 32'(valid_o), 32'd1);
      chk("b2b_result", result_o, 32'(i * 10 + 1));
      chk("b2b_tag", 32'(tag_o), 32'(10 + i));
    end
    valid_i = 1'b0;

    // Flush mid-shift when the counter reaches 2.
    send(4'd5, 32'hF0F0_0000, 32'd6, 5'd12, w);
    for (int i = 0; i < 4; i++) begin
`ifndef ALU_BARREL_SHIFT_EN
      chk("flush_pre_valid", 32'(valid_o), 32'd0);
`endif
      @(posedge clk_i); #1;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_busy", 32'(busy_o), 32'd0);
    send(4'd0, 32'd2, 32'd3, 5'd13, w);
    chk("flush_next_wait", 32'(w), 32'd0);
    chk("flush_next_result", result_o, 32'd5);

    // Flush in the same cycle as a request drops it and keeps the old result.
    flush_i = 1'b1; valid_i = 1'b1; alu_ctrl_i = 4'd0; op_a_i = 32'd9; op_b_i = 32'd9; tag_i = 5'd14;
    #1;
    chk("flushreq_ready", 32'(ready_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flushreq_valid", 32'(valid_o), 32'd0);
    chk("flushreq_result", result_o, 32'd5);
    chk("flushreq_tag", 32'(tag_o), 32'd13);

    // Asynchronous reset in the middle of a shift.
    send(4'd4, 32'd1, 32'd10, 5'd15, w);
    @(posedge clk_i); #3;
`ifndef ALU_BARREL_SHIFT_EN
    chk("areset_pre_busy", 32'(busy_o), 32'd1);
`endif
    rst_ni = 1'b0;
    #1;
    chk("areset_valid", 32'(valid_o), 32'd0);
    chk("areset_busy", 32'(busy_o), 32'd0);
    chk("areset_result", result_o, 32'd0);
    chk("areset_tag", 32'(tag_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    send(4'd0, 32'd1, 32'd1, 5'd1, w);
    chk("post_reset_result", result_o, 32'd2);
    chk("post_reset_valid", 32'(valid_o), 32'd1);

    // Randomized traffic with backpressure and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      ready_i    = ($urandom_range(0, 3) != 0);
      flush_i    = ($urandom_range(0, 39) == 0);
      valid_i    = 1'($urandom_range(0, 1));
      alu_ctrl_i = 4'($urandom_range(0, 15));
      op_a_i     = $urandom();
      op_b_i     = $urandom();
      if ($urandom_range(0, 3) == 0) op_b_i = op_a_i;
      tag_i      = 5'($urandom());
      @(posedge clk_i); #1;
    end
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
